vga_scan_engine: RTL and testbench
==================================

VGA_SCAN_ENGINE -- requirements
Module: vga_scan_engine

Interface
REQ-001 Param H_ACTIVE, 640, visible pixels per line.
REQ-002 Param H_FP / H_SYNC / H_BP, 19 / 96 / 45, horizontal porch and sync widths in clocks (total 800).
REQ-003 Param V_ACTIVE, 480, visible lines per frame.
REQ-004 Param V_FP / V_SYNC / V_BP, 13 / 2 / 30, vertical porch and sync widths in lines (total 525).
REQ-005 Param SCALE_SHIFT, 1, dot size is 2^SCALE_SHIFT x 2^SCALE_SHIFT pixels; legal values 0..2.
REQ-006 Param BPC, 1, bits per colour channel; legal values 1..4.
REQ-007 Param MEM_LATENCY, 1, video-memory read latency in clocks; legal values 1..3.
REQ-008 Param SYNC_ACTIVE_HIGH, 0, HS/VS polarity; 0 means active-low.
REQ-009 Localparam ADDR_W = clog2((H_ACTIVE>>SCALE_SHIFT)*(V_ACTIVE>>SCALE_SHIFT)).
REQ-010 vga_clock  in  1  pixel clock.
REQ-011 resetn  in  1  reset, asynchronous, active-low.
REQ-012 pixel_colour  in  3*BPC  read data {R,G,B}; valid MEM_LATENCY clocks after mem_rd_en.
REQ-013 swap_req  in  1  single-cycle request to exchange front and back buffers.
REQ-014 mem_addr  out  ADDR_W+1  {front_bank, dot address}.
REQ-015 mem_rd_en  out  1  high while the scan position is in the active area.
REQ-016 swap_ack  out  1  one-cycle pulse when a swap takes effect.
REQ-017 front_bank  out  1  bank currently displayed.
REQ-018 frame_start / line_start  out  1 each  one-cycle pulses at x=0,y=0 and at x=0.
REQ-019 VGA_R, VGA_G, VGA_B  out  4 each  DAC colour.
REQ-020 VGA_HS, VGA_VS, VGA_BLANK  out  1 each  sync and blank (BLANK high = visible).
REQ-021 VGA_SYNC  out  1  constant 1; VGA_CLK out 1, equal to vga_clock.

Function
REQ-022 x counter shall count 0..H_total-1 and wrap; y shall increment on x wrap and wrap at V_total-1.
REQ-023 Dot address shall be generated incrementally without a multiplier: +1 every 2^SCALE_SHIFT active pixels; at line end, reload the line base, adding H_ACTIVE>>SCALE_SHIFT to the base only after every 2^SCALE_SHIFT-th line; reset to 0 at frame start.
REQ-024 mem_addr and mem_rd_en shall be registered outputs reflecting scan position (x,y).
REQ-025 HS, VS and BLANK shall be delayed so that they align exactly with the colour returned for the same (x,y); total latency from mem_addr to VGA_R/G/B is MEM_LATENCY+1 clocks.
REQ-026 HS shall be asserted for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; VS likewise per line; polarity per SYNC_ACTIVE_HIGH.
REQ-027 Colour expansion shall replicate each channel's BPC bits MSB-first across 4 bits and truncate (BPC=1, R=1 gives 4'b1111; BPC=3, R=3'b101 gives 4'b1011).
REQ-028 VGA_R/G/B shall be forced to 0 when the aligned BLANK is low.
REQ-029 swap_req shall set a pending flag; on the first clock of vertical blanking (x=0, y=V_ACTIVE) a pending swap shall toggle front_bank, clear the flag, and pulse swap_ack.
REQ-030 swap_req arriving on the same clock as the swap point shall be taken by that swap; repeated requests before a swap shall collapse into one.
REQ-031 front_bank shall never change during the active area.

Reset
REQ-032 On resetn low: counters, dot address, line base, pending flag and front_bank = 0; mem_rd_en, swap_ack, frame_start, line_start = 0; BLANK = 0; RGB = 0; HS/VS inactive; all delay-pipeline stages cleared.
REQ-033 Reset mid-frame shall restart at x=0,y=0 on the first clock after release, with frame_start asserted there.

Structure
REQ-034 A shared package vga_pkg shall hold the default 640x480 timing constants and the clog2 function.
REQ-035 The sync/blank delay line shall be a sub-module vga_delay_line parametrised by width and depth.

Verification
REQ-036 Defaults, run 2 frames -> HS low for 96 clocks per 800-clock line, VS low for 2 lines per 525, frame_start period 420000 clocks.
REQ-037 SCALE_SHIFT=1 -> mem_addr (bank stripped) 0,0,1,1,... on lines 0 and 1; line 2 starts at 320; last active address 76799.
REQ-038 MEM_LATENCY=3, memory model returning the address as data -> first visible RGB equals data for address 0, coinciding with the BLANK rising edge.
REQ-039 swap_req pulsed mid-frame and again 5 clocks later -> exactly one swap_ack at x=0,y=480; front_bank toggles there only.
REQ-040 BPC=2, pixel_colour=6'b10_01_11 -> VGA_R=4'b1010, VGA_G=4'b0101, VGA_B=4'b1111.
REQ-041 resetn asserted at y=200 -> outputs at reset values immediately; scan restarts at 0,0 with frame_start.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480 timing, shared sync bundle type and elaboration helpers.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 19;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 45;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 13;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 30;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } vga_sync_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Replicates the low bpc bits of c MSB-first across a 4-bit DAC code.
    function automatic logic [3:0] expand(input logic [3:0] c, input int bpc);
        logic [3:0] o;
        logic [3:0] sh;
        o = '0;
        for (int i = 0; i < 4; i++) begin
            sh = c >> (bpc - 1 - (i % bpc));
            o  = {o[2:0], sh[0]};
        end
        return o;
    endfunction

endpackage

// File: rtl/vga_scan_engine_if.sv
// vga_scan_engine_if: video-memory read bus, buffer-swap handshake and VGA DAC outputs.
interface vga_scan_engine_if #(
    parameter int ADDR_W = 17,
    parameter int BPC    = 1
);
    logic [3*BPC-1:0] pixel_colour;
    logic             swap_req;
    logic [ADDR_W:0]  mem_addr;
    logic             mem_rd_en;
    logic             swap_ack;
    logic             front_bank;
    logic             frame_start;
    logic             line_start;
    logic [3:0]       VGA_R;
    logic [3:0]       VGA_G;
    logic [3:0]       VGA_B;
    logic             VGA_HS;
    logic             VGA_VS;
    logic             VGA_BLANK;
    logic             VGA_SYNC;
    logic             VGA_CLK;

    modport master (
        input  pixel_colour, swap_req,
        output mem_addr, mem_rd_en, swap_ack, front_bank, frame_start, line_start,
        output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_CLK
    );

    modport slave (
        output pixel_colour, swap_req,
        input  mem_addr, mem_rd_en, swap_ack, front_bank, frame_start, line_start,
        input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_CLK
    );
endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage register pipeline, cleared by reset.
module vga_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 1
) (
    input  logic             vga_clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/vga_scan_engine.sv
// vga_scan_engine: VGA raster scanner reading scaled dots from a double-buffered
// video memory, with sync/blank aligned to the returned colour.
module vga_scan_engine
    import vga_pkg::*;
#(
    parameter int H_ACTIVE         = H_ACTIVE_DEF,
    parameter int H_FP             = H_FP_DEF,
    parameter int H_SYNC           = H_SYNC_DEF,
    parameter int H_BP             = H_BP_DEF,
    parameter int V_ACTIVE         = V_ACTIVE_DEF,
    parameter int V_FP             = V_FP_DEF,
    parameter int V_SYNC           = V_SYNC_DEF,
    parameter int V_BP             = V_BP_DEF,
    parameter int SCALE_SHIFT      = 1,
    parameter int BPC              = 1,
    parameter int MEM_LATENCY      = 1,
    parameter int SYNC_ACTIVE_HIGH = 0
) (
    input logic vga_clock,
    input logic resetn,
    vga_scan_engine_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_DOTS  = H_ACTIVE >> SCALE_SHIFT;
    localparam int ADDR_W  = clog2(H_DOTS * (V_ACTIVE >> SCALE_SHIFT));
    localparam int XW      = clog2(H_TOTAL);
    localparam int YW      = clog2(V_TOTAL);
    localparam logic [XW-1:0] X_MASK = XW'((1 << SCALE_SHIFT) - 1);
    localparam logic [YW-1:0] Y_MASK = YW'((1 << SCALE_SHIFT) - 1);
    localparam logic POL_INV = (SYNC_ACTIVE_HIGH == 0);

    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] dot_q, dot_d, base_q, base_d;
    logic              pend_q, pend_d, front_q, front_d;
    logic              active, x_end, y_end, do_swap;
    logic [ADDR_W:0]   addr_q;
    logic              rd_en_q, ack_q, fs_q, ls_q;
    logic [11:0]       rgb_q;
    vga_sync_t         sync0_d, sync0_q, sync_dly, sync_q;

    always_comb begin
        x_end   = x_q == XW'(H_TOTAL - 1);
        y_end   = y_q == YW'(V_TOTAL - 1);
        active  = x_q < XW'(H_ACTIVE) && y_q < YW'(V_ACTIVE);
        do_swap = x_q == '0 && y_q == YW'(V_ACTIVE) && (pend_q || bus.swap_req);
        x_d     = x_end ? '0 : x_q + XW'(1);
        y_d     = !x_end ? y_q : y_end ? '0 : y_q + YW'(1);
        // The line base only advances once all 2^SCALE_SHIFT repeats of a dot row are drawn.
        base_d  = !x_end ? base_q : y_end ? '0 :
                  (y_q & Y_MASK) == Y_MASK ? base_q + ADDR_W'(H_DOTS) : base_q;
        dot_d   = x_end ? base_d : (active && (x_q & X_MASK) == X_MASK) ? dot_q + ADDR_W'(1) : dot_q;
        pend_d  = !do_swap && (pend_q || bus.swap_req);
        front_d = front_q ^ do_swap;
        sync0_d.hs    = x_q >= XW'(H_ACTIVE + H_FP) && x_q < XW'(H_ACTIVE + H_FP + H_SYNC);
        sync0_d.vs    = y_q >= YW'(V_ACTIVE + V_FP) && y_q < YW'(V_ACTIVE + V_FP + V_SYNC);
        sync0_d.blank = active;
    end

    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            x_q     <= '0;
            y_q     <= '0;
            dot_q   <= '0;
            base_q  <= '0;
            pend_q  <= 1'b0;
            front_q <= 1'b0;
            addr_q  <= '0;
            rd_en_q <= 1'b0;
            ack_q   <= 1'b0;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
            sync0_q <= '0;
            sync_q  <= '0;
            rgb_q   <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            dot_q   <= dot_d;
            base_q  <= base_d;
            pend_q  <= pend_d;
            front_q <= front_d;
            addr_q  <= {front_q, dot_q};
            rd_en_q <= active;
            ack_q   <= do_swap;
            fs_q    <= x_q == '0 && y_q == '0;
            ls_q    <= x_q == '0;
            sync0_q <= sync0_d;
            sync_q  <= sync_dly;
            rgb_q   <= sync_dly.blank ? {expand(4'(bus.pixel_colour[3*BPC-1 -: BPC]), BPC),
                                         expand(4'(bus.pixel_colour[2*BPC-1 -: BPC]), BPC),
                                         expand(4'(bus.pixel_colour[BPC-1:0]), BPC)} : '0;
        end
    end

    // Holds sync/blank back until the memory data for the same position arrives.
    vga_delay_line #(
        .WIDTH($bits(vga_sync_t)),
        .DEPTH(MEM_LATENCY)
    ) u_sync_dly (
        .vga_clock(vga_clock),
        .resetn   (resetn),
        .d_i      (sync0_q),
        .q_o      (sync_dly)
    );

    assign bus.mem_addr    = addr_q;
    assign bus.mem_rd_en   = rd_en_q;
    assign bus.swap_ack    = ack_q;
    assign bus.front_bank  = front_q;
    assign bus.frame_start = fs_q;
    assign bus.line_start  = ls_q;
    assign {bus.VGA_R, bus.VGA_G, bus.VGA_B} = rgb_q;
    assign bus.VGA_HS      = sync_q.hs ^ POL_INV;
    assign bus.VGA_VS      = sync_q.vs ^ POL_INV;
    assign bus.VGA_BLANK   = sync_q.blank;
    assign bus.VGA_SYNC    = 1'b1;
    assign bus.VGA_CLK     = vga_clock;
endmodule

// File: tb/tb_vga_scan_engine.sv
// tb_vga_scan_engine: reduced-timing scan check against a position-arithmetic model,
// with a latency-3 random-content memory and random buffer-swap requests.
module tb_vga_scan_engine;
    localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
    localparam int VA = 8, VFP = 1, VSY = 2, VBP = 2;
    localparam int S = 1, BPC = 2, L = 3, POL = 0;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;
    localparam int HD = HA >> S;
    localparam int AW = 5;
    localparam int CW = 3 * BPC;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int tests = 0, fails = 0;
    int c = 0, seg = 0;
    int fs_last = 0, hs_low = 0, vs_low = 0, ack_cnt = 0;
    logic m_front = 1'b0, m_pend = 1'b0, m_ack = 1'b0;
    logic [CW-1:0] mem [2**(AW+1)];
    logic [CW-1:0] pipe [L];
    logic [11:0] hist [4096];
    int lit_c [10] = '{1, 2, 3, 4, 25, 26, 27, 28, 49, 184};
    int lit_a [10] = '{0, 0, 1, 1, 0, 0, 1, 1, 8, 31};

    vga_scan_engine_if #(.ADDR_W(AW), .BPC(BPC)) bus();

    vga_scan_engine #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .SCALE_SHIFT(S), .BPC(BPC), .MEM_LATENCY(L), .SYNC_ACTIVE_HIGH(POL)
    ) dut (
        .vga_clock(clk),
        .resetn   (resetn),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    // Memory returns junk when not read so that blank forcing is exercised.
    always @(posedge clk) begin
        pipe[0] <= bus.mem_rd_en ? mem[bus.mem_addr] : CW'($urandom);
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.pixel_colour = pipe[L-1];

    function automatic logic [3:0] exp4(input logic [BPC-1:0] v);
        logic [4*BPC-1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r = {r[3*BPC-1:0], v};
        return r[4*BPC-1 -: 4];
    endfunction

    function automatic logic [11:0] colour(input logic [CW-1:0] d);
        return {exp4(d[CW-1 -: BPC]), exp4(d[2*BPC-1 -: BPC]), exp4(d[BPC-1:0])};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s seg%0d cycle %0d: got %0d expected %0d", nm, seg, c, act, exp);
        end
    endtask

    task automatic check_cycle();
        int p, x, y, q, qx, qy, dot;
        logic act, eb, ehs, evs;
        logic [11:0] ergb;
        dot = 0;
        if (c == 0) begin
            chk("rd_en", int'(bus.mem_rd_en), 0);
            chk("addr", int'(bus.mem_addr), 0);
            chk("frame_start", int'(bus.frame_start), 0);
            chk("line_start", int'(bus.line_start), 0);
        end else begin
            p = c - 1;
            x = p % HT;
            y = (p / HT) % VT;
            act = x < HA && y < VA;
            chk("rd_en", int'(bus.mem_rd_en), int'(act));
            chk("frame_start", int'(bus.frame_start), int'(x == 0 && y == 0));
            chk("line_start", int'(bus.line_start), int'(x == 0));
            if (act) begin
                dot = (y >> S) * HD + (x >> S);
                chk("addr", int'(bus.mem_addr), int'({m_front, dot[AW-1:0]}));
            end
            hist[c] = act ? colour(mem[{m_front, dot[AW-1:0]}]) : 12'h0;
        end
        chk("swap_ack", int'(bus.swap_ack), int'(m_ack));
        chk("front_bank", int'(bus.front_bank), int'(m_front));
        if (c < L + 2) begin
            eb = 1'b0; ehs = 1'b0; evs = 1'b0; ergb = '0;
        end else begin
            q = c - L - 2;
            qx = q % HT;
            qy = (q / HT) % VT;
            eb = qx < HA && qy < VA;
            ehs = qx >= HA + HFP && qx < HA + HFP + HSY;
            evs = qy >= VA + VFP && qy < VA + VFP + VSY;
            ergb = hist[c - L - 1];
        end
        chk("vga_rgb", int'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), int'(ergb));
        chk("vga_blank", int'(bus.VGA_BLANK), int'(eb));
        chk("vga_hs", int'(bus.VGA_HS), int'(ehs ^ (POL == 0)));
        chk("vga_vs", int'(bus.VGA_VS), int'(evs ^ (POL == 0)));
        chk("vga_sync", int'(bus.VGA_SYNC), 1);
    endtask

    // Hand-computed anchors for the 16x8 / 2x2-dot / latency-3 configuration.
    task automatic literal_checks();
        logic [AW-1:0] a;
        a = bus.mem_addr[AW-1:0];
        for (int i = 0; i < 10; i++)
            if (seg == 1 && c == lit_c[i]) chk("addr_lit", int'(a), lit_a[i]);
        if (bus.frame_start) begin
            if (fs_last > 0) chk("fs_period", c - fs_last, 312);
            fs_last = c;
        end
        if (seg == 2 && c == 1) chk("fs_after_reset", int'(bus.frame_start), 1);
        if (seg != 1) return;
        if (c == 4) chk("blank_before_first", int'(bus.VGA_BLANK), 0);
        if (c == 5) begin
            chk("blank_first", int'(bus.VGA_BLANK), 1);
            chk("r_first", int'(bus.VGA_R), 10);
            chk("g_first", int'(bus.VGA_G), 5);
            chk("b_first", int'(bus.VGA_B), 15);
        end
        if (c >= 5 && c < 5 + FRAME) begin
            hs_low += int'(!bus.VGA_HS);
            vs_low += int'(!bus.VGA_VS);
        end
        if (c == 5 + FRAME) begin
            chk("hs_low_frame", hs_low, 39);
            chk("vs_low_frame", vs_low, 48);
        end
        if (c <= 312) ack_cnt += int'(bus.swap_ack);
        if (c == 312) chk("ack_count_f0", ack_cnt, 1);
        if (c == 193) chk("ack_f0", int'(bus.swap_ack), 1);
        if (c == 505) chk("ack_same_clock", int'(bus.swap_ack), 1);
    endtask

    task automatic advance(input logic r);
        if ((c % FRAME) == VA * HT && (m_pend || r)) begin
            m_front = !m_front;
            m_pend = 1'b0;
            m_ack = 1'b1;
        end else begin
            m_ack = 1'b0;
            m_pend = m_pend || r;
        end
        bus.swap_req = r;
        @(negedge clk);
        c++;
    endtask

    task automatic start_segment(input int n);
        resetn = 1'b1;
        c = 0;
        fs_last = 0;
        m_front = 1'b0;
        m_pend = 1'b0;
        m_ack = 1'b0;
        seg = n;
    endtask

    initial begin
        logic r;
        bus.swap_req = 1'b0;
        for (int i = 0; i < 2**(AW+1); i++) mem[i] = CW'($urandom);
        mem[0] = 6'b10_01_11;
        repeat (3) @(negedge clk);
        start_segment(1);
        for (int i = 0; i < 1063; i++) begin
            check_cycle();
            literal_checks();
            r = (c == 100 || c == 105 || c == 504) || (c >= 600 && $urandom_range(0, 39) == 0);
            advance(r);
        end
        resetn = 1'b0;
        #1;
        chk("rst_rd_en", int'(bus.mem_rd_en), 0);
        chk("rst_addr", int'(bus.mem_addr), 0);
        chk("rst_ack", int'(bus.swap_ack), 0);
        chk("rst_front", int'(bus.front_bank), 0);
        chk("rst_fs", int'(bus.frame_start), 0);
        chk("rst_ls", int'(bus.line_start), 0);
        chk("rst_blank", int'(bus.VGA_BLANK), 0);
        chk("rst_rgb", int'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 0);
        chk("rst_hs", int'(bus.VGA_HS), 1);
        chk("rst_vs", int'(bus.VGA_VS), 1);
        bus.swap_req = 1'b0;
        repeat (2) @(negedge clk);
        start_segment(2);
        for (int i = 0; i < 700; i++) begin
            check_cycle();
            literal_checks();
            r = $urandom_range(0, 29) == 0;
            advance(r);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
